// File: rtl/rv_iopmp_check_queue.sv
// rv_iopmp_check_queue: request FIFO in front of the IOPMP matching logic.
// Upstream check requests are queued, and only one check at a time is issued
// to the matching logic. Each verdict is held for the data abstractor until it
// is accepted.
// Optional statistics outputs (deny counter, occupancy high-water mark) are
// enabled by defining RV_IOPMP_CHECKQ_STATS_EN.

package rv_iopmp_pkg;
    typedef enum logic [0:0] {
        ACCESS_READ  = 1'b0,
        ACCESS_WRITE = 1'b1
    } access_t;
endpackage

module rv_iopmp_check_queue #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned SID_WIDTH  = 1,
    parameter int unsigned NB_WIDTH   = 4,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [ADDR_WIDTH-1:0]   total_length_i,
    input  logic [NB_WIDTH-1:0]     num_bytes_i,
    input  logic [SID_WIDTH-1:0]    sid_i,
    input  rv_iopmp_pkg::access_t   access_type_i,
    output logic                    transaction_en_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [ADDR_WIDTH-1:0]   total_length_o,
    output logic [NB_WIDTH-1:0]     num_bytes_o,
    output logic [SID_WIDTH-1:0]    sid_o,
    output rv_iopmp_pkg::access_t   access_type_o,
    input  logic                    chk_ready_i,
    input  logic                    chk_valid_i,
    input  logic                    chk_allow_i,
    input  logic                    stall_i,
    output logic                    rsp_valid_o,
    output logic                    rsp_allow_o,
    input  logic                    rsp_ready_i,
    output logic                    empty_o,
    output logic                    full_o
`ifdef RV_IOPMP_CHECKQ_STATS_EN
    ,
    output logic [31:0]             deny_count_o,
    output logic [$clog2(DEPTH):0]  max_occ_o
`endif
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ACC_W   = $bits(rv_iopmp_pkg::access_t);
    localparam int unsigned ENTRY_W = 2 * ADDR_WIDTH + NB_WIDTH + SID_WIDTH + ACC_W;

    // Entry layout, MSB to LSB: {addr, total_length, num_bytes, sid, access_type}
    localparam int unsigned ACC_LSB  = 0;
    localparam int unsigned SID_LSB  = ACC_LSB + ACC_W;
    localparam int unsigned NB_LSB   = SID_LSB + SID_WIDTH;
    localparam int unsigned LEN_LSB  = NB_LSB + NB_WIDTH;
    localparam int unsigned ADDR_LSB = LEN_LSB + ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               verdict_reg, verdict_next;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [ENTRY_W-1:0] head_reg;
    logic [ENTRY_W-1:0] entry_in;
    logic               push, pop, load_head;

    assign entry_in    = {addr_i, total_length_i, num_bytes_i, sid_i, access_type_i};
    assign full_o      = (count_reg == CNT_W'(DEPTH));
    assign empty_o     = (count_reg == '0);
    assign req_ready_o = !full_o;
    assign push        = req_valid_i && req_ready_o;

    // Head entry fields presented to the matching logic
    assign addr_o         = head_reg[ADDR_LSB +: ADDR_WIDTH];
    assign total_length_o = head_reg[LEN_LSB +: ADDR_WIDTH];
    assign num_bytes_o    = head_reg[NB_LSB +: NB_WIDTH];
    assign sid_o          = head_reg[SID_LSB +: SID_WIDTH];
    assign access_type_o  = rv_iopmp_pkg::access_t'(head_reg[ACC_LSB +: ACC_W]);

    // Check sequencer: next state, issue strobe, response handshake, pop
    always_comb begin
        state_next       = state_reg;
        verdict_next     = verdict_reg;
        transaction_en_o = 1'b0;
        rsp_valid_o      = 1'b0;
        rsp_allow_o      = 1'b0;
        pop              = 1'b0;
        load_head        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A push into an empty queue is issued on the very next cycle
                if ((!empty_o || push) && !stall_i) begin
                    state_next = ST_ISSUE;
                    load_head  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!stall_i) begin
                    transaction_en_o = 1'b1;
                    if (chk_ready_i) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (chk_valid_i) begin
                    verdict_next = chk_allow_i;
                    state_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_allow_o = verdict_reg;
                if (rsp_ready_i) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Control state, pointers, occupancy and captured verdict
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            verdict_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            verdict_reg <= verdict_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Entry storage write port (data is never reset)
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= entry_in;
        end
    end

    // Registered head read; bypass the inputs when pushing into an empty queue
    always_ff @(posedge clk_i) begin
        if (load_head) begin
            head_reg <= empty_o ? entry_in : fifo_mem[rd_ptr_reg];
        end
    end

`ifdef RV_IOPMP_CHECKQ_STATS_EN
    logic [31:0]      deny_count_reg;
    logic [CNT_W-1:0] max_occ_reg;

    assign deny_count_o = deny_count_reg;
    assign max_occ_o    = max_occ_reg;

    // Saturating deny counter and occupancy high-water mark
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deny_count_reg <= '0;
            max_occ_reg    <= '0;
        end else begin
            if (pop && !verdict_reg && (deny_count_reg != '1)) begin
                deny_count_reg <= deny_count_reg + 32'd1;
            end
            if (count_next > max_occ_reg) begin
                max_occ_reg <= count_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv_iopmp_check_queue.sv
// Testbench for rv_iopmp_check_queue: directed scenarios followed by random
// traffic, all checked against a transaction-level queue model.
module tb_rv_iopmp_check_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] len;
        logic [3:0]  nb;
        logic        sid;
        logic        acc;
    } ent_t;

    logic clk_i = 1'b0;
    logic rst_i;
    logic req_valid_i, req_ready_o;
    logic [63:0] addr_i, total_length_i;
    logic [3:0]  num_bytes_i;
    logic [0:0]  sid_i;
    rv_iopmp_pkg::access_t access_type_i;
    logic transaction_en_o;
    logic [63:0] addr_o, total_length_o;
    logic [3:0]  num_bytes_o;
    logic [0:0]  sid_o;
    rv_iopmp_pkg::access_t access_type_o;
    logic chk_ready_i, chk_valid_i, chk_allow_i, stall_i;
    logic rsp_valid_o, rsp_allow_o, rsp_ready_i;
    logic empty_o, full_o;
`ifdef RV_IOPMP_CHECKQ_STATS_EN
    logic [31:0] deny_count_o;
    logic [2:0]  max_occ_o;
`endif

    rv_iopmp_check_queue dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .addr_i(addr_i), .total_length_i(total_length_i),
        .num_bytes_i(num_bytes_i), .sid_i(sid_i), .access_type_i(access_type_i),
        .transaction_en_o(transaction_en_o),
        .addr_o(addr_o), .total_length_o(total_length_o),
        .num_bytes_o(num_bytes_o), .sid_o(sid_o), .access_type_o(access_type_o),
        .chk_ready_i(chk_ready_i), .chk_valid_i(chk_valid_i), .chk_allow_i(chk_allow_i),
        .stall_i(stall_i),
        .rsp_valid_o(rsp_valid_o), .rsp_allow_o(rsp_allow_o), .rsp_ready_i(rsp_ready_i),
        .empty_o(empty_o), .full_o(full_o)
`ifdef RV_IOPMP_CHECKQ_STATS_EN
        , .deny_count_o(deny_count_o), .max_occ_o(max_occ_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard state
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;
    int   exp_en   = -1;   // -1: no exact expectation for transaction_en_o
    ent_t q[$];            // queued requests in push order
    bit   issued;          // check handed to matching logic, verdict not yet seen
    bit   have_verdict;    // verdict awaiting acceptance downstream
    bit   verdict;
    bit   last_push;
    int   deny_cnt;
    int   max_occ;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        issued       = 0;
        have_verdict = 0;
        verdict      = 0;
        deny_cnt     = 0;
        max_occ      = 0;
    endtask

    task automatic idle_inputs();
        req_valid_i    = 0;
        addr_i         = '0;
        total_length_i = '0;
        num_bytes_i    = '0;
        sid_i          = '0;
        access_type_i  = rv_iopmp_pkg::ACCESS_READ;
        chk_ready_i    = 0;
        chk_valid_i    = 0;
        chk_allow_i    = 0;
        stall_i        = 0;
        rsp_ready_i    = 0;
    endtask

    task automatic rand_fields();
        addr_i         = {$urandom, $urandom};
        total_length_i = {$urandom, $urandom};
        num_bytes_i    = 4'($urandom_range(15, 0));
        sid_i          = 1'($urandom_range(1, 0));
        access_type_i  = rv_iopmp_pkg::access_t'($urandom_range(1, 0));
    endtask

    // One clock cycle: check outputs at the falling edge, update the model at the rising edge
    task automatic step();
        bit push, pop, issue_hs, verdict_in;
        ent_t e;
        @(negedge clk_i);
        check("empty_o", empty_o, q.size() == 0);
        check("full_o", full_o, q.size() == DEPTH);
        check("req_ready_o", req_ready_o, q.size() < DEPTH);
        check("rsp_valid_o", rsp_valid_o, have_verdict);
        if (have_verdict) check("rsp_allow_o", rsp_allow_o, verdict);
        if (stall_i) check("en_during_stall", transaction_en_o, 0);
        if (exp_en >= 0) check("transaction_en_o", transaction_en_o, exp_en[0]);
`ifdef RV_IOPMP_CHECKQ_STATS_EN
        check("deny_count_o", deny_count_o, deny_cnt);
        check("max_occ_o", max_occ_o, max_occ);
`endif
        issue_hs = 0;
        if (transaction_en_o) begin
            check("one_outstanding", {issued, have_verdict}, 0);
            check("issue_has_entry", q.size() > 0, 1);
            if (q.size() > 0) begin
                check("addr_o", addr_o, q[0].addr);
                check("total_length_o", total_length_o, q[0].len);
                check("num_bytes_o", num_bytes_o, q[0].nb);
                check("sid_o", sid_o, q[0].sid);
                check("access_type_o", access_type_o, q[0].acc);
            end
            issue_hs = chk_ready_i;
        end
        push       = req_valid_i && (q.size() < DEPTH);
        pop        = have_verdict && rsp_ready_i;
        verdict_in = issued && chk_valid_i;
        e.addr = addr_i; e.len = total_length_i; e.nb = num_bytes_i;
        e.sid  = sid_i;  e.acc = access_type_i;
        @(posedge clk_i);
        if (pop) begin
            n_txn++;
            $display("txn %0d: addr=%h allow=%0d", n_txn, q[0].addr, verdict);
            if (!verdict) deny_cnt++;
            void'(q.pop_front());
            have_verdict = 0;
        end
        if (push) q.push_back(e);
        if (issue_hs) issued = 1;
        if (verdict_in) begin
            issued       = 0;
            have_verdict = 1;
            verdict      = chk_allow_i;
        end
        if (q.size() > max_occ) max_occ = q.size();
        last_push = push;
        exp_en    = -1;
        #1;
    endtask

    // Complete every queued check with a cooperative downstream
    task automatic drain(input bit allow);
        int n;
        idle_inputs();
        chk_ready_i = 1;
        rsp_ready_i = 1;
        chk_allow_i = allow;
        n = 0;
        while ((q.size() > 0 || issued || have_verdict) && n < 200) begin
            chk_valid_i = issued;
            step();
            n++;
        end
        check("drain_done", n < 200, 1);
        idle_inputs();
    endtask

    initial begin
        int k;
        idle_inputs();
        model_clear();
        rst_i = 1;
        #1;
        // Reset state
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_en", transaction_en_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_allow", rsp_allow_o, 0);
        check("rst_req_ready", req_ready_o, 1);
`ifdef RV_IOPMP_CHECKQ_STATS_EN
        check("rst_deny_count", deny_count_o, 0);
        check("rst_max_occ", max_occ_o, 0);
`endif
        step();
        step();
        rst_i = 0;
        step();

        // Single request: issue one cycle after the push, allow after 2 cycles
        req_valid_i = 1; addr_i = 64'h1000; total_length_i = 64'd8; num_bytes_i = 4'd4;
        exp_en = 0;
        step();
        idle_inputs();
        chk_ready_i = 1; chk_allow_i = 1; rsp_ready_i = 1;
        exp_en = 1; step();
        exp_en = 0; step();
        chk_valid_i = 1;
        exp_en = 0; step();
        chk_valid_i = 0;
        check("single_rsp_valid", rsp_valid_o, 1);
        check("single_rsp_allow", rsp_allow_o, 1);
        step();
        check("single_empty_after", empty_o, 1);
        exp_en = 0; step();

        // Five back-to-back pushes with the response held off
        k = 0;
        chk_ready_i = 1; chk_allow_i = 1;
        for (int j = 0; j < 14; j++) begin
            req_valid_i = (k < 5);
            addr_i      = 64'h2000 + 64'(k);
            chk_valid_i = issued;
            rsp_ready_i = (j >= 8);
            step();
            if (last_push) k++;
            if (k == 4 && j < 8) check("full_after_4th", {full_o, req_ready_o}, 2'b10);
        end
        check("fifth_accepted", k, 5);
        drain(1);

        // Stall for three cycles while the check is being issued
        req_valid_i = 1; addr_i = 64'h4000; total_length_i = 64'd16;
        step();
        idle_inputs();
        stall_i = 1; chk_ready_i = 1;
        for (int j = 0; j < 3; j++) begin
            exp_en = 0; step();
        end
        stall_i = 0;
        exp_en = 1; step();
        drain(1);

        // Reset during WAIT with three entries queued
        chk_ready_i = 1;
        for (int j = 0; j < 3; j++) begin
            req_valid_i = 1; rand_fields();
            step();
        end
        idle_inputs();
        check("pre_rst_waiting", {issued, q.size() == 3}, 2'b11);
        rst_i = 1;
        #1;
        check("midrst_empty", empty_o, 1);
        check("midrst_rsp_valid", rsp_valid_o, 0);
        check("midrst_en", transaction_en_o, 0);
        model_clear();
        step();
        rst_i = 0;
        for (int j = 0; j < 5; j++) begin
            exp_en = 0; step();
        end

        // Deny verdict held for five cycles before acceptance
        req_valid_i = 1; addr_i = 64'h5000; total_length_i = 64'd4;
        step();
        idle_inputs();
        chk_ready_i = 1;
        step();
        chk_valid_i = 1; chk_allow_i = 0;
        step();
        chk_valid_i = 0; chk_allow_i = 1;
        for (int j = 0; j < 5; j++) begin
            check("deny_hold_valid", rsp_valid_o, 1);
            check("deny_hold_allow", rsp_allow_o, 0);
            step();
        end
        rsp_ready_i = 1;
        step();
        idle_inputs();
`ifdef RV_IOPMP_CHECKQ_STATS_EN
        check("deny_count_one", deny_count_o, 1);
`endif

        // DEPTH+3 sequential requests with distinct addresses (pointer wrap)
        k = 0;
        chk_ready_i = 1; rsp_ready_i = 1; chk_allow_i = 1;
        for (int j = 0; j < 200 && (k < DEPTH + 3 || q.size() > 0); j++) begin
            req_valid_i = (k < DEPTH + 3);
            addr_i      = 64'h3000 + 64'(k * 16);
            chk_valid_i = issued;
            step();
            if (last_push) k++;
        end
        check("wrap_all_pushed", k, DEPTH + 3);
        drain(1);

        // Random traffic
        for (int j = 0; j < 400; j++) begin
            req_valid_i = 1'($urandom_range(1, 0));
            rand_fields();
            stall_i     = ($urandom_range(9, 0) == 0);
            chk_ready_i = 1'($urandom_range(1, 0));
            chk_valid_i = issued && ($urandom_range(1, 0) == 1);
            chk_allow_i = 1'($urandom_range(1, 0));
            rsp_ready_i = 1'($urandom_range(1, 0));
            step();
        end
        drain(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
